// File: rtl/text_console_writer.sv
// text_console_writer
//
// Character-stream front end for the text-mode display buffer. Bytes arrive
// over a valid/ready handshake. Printable characters are written at a linear
// cursor. CR, LF, BS and FF move the cursor or clear the screen. Every other
// byte is swallowed. The display buffer write port (wraddr/wrdata/we) is fully
// registered, so a write appears in the cycle after the accepting edge.
//
// Optional feature macro: CONSOLE_LINECLR_EN
//   When it is defined, every line advance (LF or end-of-line wrap) blanks the
//   new row through an extra LINECLR fill state. When it is undefined, a line
//   advance only moves the cursor, and the old row contents stay on screen.
//
// The cursor is tracked as (row, column, row base address). This means the
// linear address row*COLS+col never needs a multiplier or a divider. The row
// base steps by COLS on each line advance and wraps back to 0 explicitly.

module text_console_writer #(
    parameter int          COLS  = 80,
    parameter int          ROWS  = 30,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] wraddr,
    output logic [7:0]  wrdata,
    output logic        we,
    output logic [11:0] cursor,
    output logic        busy
);

    // Screen geometry as 12-bit constants so all address arithmetic stays 12 bits wide
    localparam logic [11:0] LAST_ADDR = 12'(COLS * ROWS - 1);
    localparam logic [11:0] LAST_COL  = 12'(COLS - 1);
    localparam logic [11:0] LAST_ROW  = 12'(ROWS - 1);
    localparam logic [11:0] ROW_STEP  = 12'(COLS);

    // Control bytes understood by the console
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

`ifdef CONSOLE_LINECLR_EN
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_LINECLR = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1
    } state_t;
`endif

    state_t      r_state;

    // Cursor bookkeeping: column, row, and the linear address of column 0 of that row
    logic [11:0] r_col;
    logic [11:0] r_row;
    logic [11:0] r_rowBase;
    logic [11:0] r_cursor;

    // Fill engine: current address and the inclusive last address of this fill
    logic [11:0] r_fill;
    logic [11:0] r_fillEnd;

    // Registered display buffer write port
    logic [11:0] r_wraddr;
    logic [7:0]  r_wrdata;
    logic        r_we;

    // Byte classification of the incoming character
    logic        w_isPrint;
    logic        w_isCR;
    logic        w_isLF;
    logic        w_isBS;
    logic        w_isFF;
    logic        w_lineAdvance;

    // Cursor position after a line advance and after a backspace
    logic [11:0] w_nextRow;
    logic [11:0] w_nextRowBase;
    logic [11:0] w_prevCol;
    logic [11:0] w_prevRow;
    logic [11:0] w_prevRowBase;

    // Decode the incoming byte; a line advance is an LF or a printable byte in the last column
    always_comb begin
        w_isPrint     = (in_data >= 8'h20) && (in_data <= 8'h7E);
        w_isCR        = (in_data == CH_CR);
        w_isLF        = (in_data == CH_LF);
        w_isBS        = (in_data == CH_BS);
        w_isFF        = (in_data == CH_FF);
        w_lineAdvance = w_isLF || (w_isPrint && (r_col == LAST_COL));
    end

    // Neighbouring cursor positions; the bottom row wraps to the top with no scrolling
    always_comb begin
        if (r_row == LAST_ROW) begin
            w_nextRow     = 12'd0;
            w_nextRowBase = 12'd0;
        end else begin
            w_nextRow     = r_row + 12'd1;
            w_nextRowBase = r_rowBase + ROW_STEP;
        end

        if (r_col == 12'd0) begin
            w_prevCol     = LAST_COL;
            w_prevRow     = r_row - 12'd1;
            w_prevRowBase = r_rowBase - ROW_STEP;
        end else begin
            w_prevCol     = r_col - 12'd1;
            w_prevRow     = r_row;
            w_prevRowBase = r_rowBase;
        end
    end

    // Main state machine: byte interpretation in IDLE, one blank write per cycle in fill states
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_col     <= 12'd0;
            r_row     <= 12'd0;
            r_rowBase <= 12'd0;
            r_cursor  <= 12'd0;
            r_fill    <= 12'd0;
            r_fillEnd <= LAST_ADDR;
            r_wraddr  <= 12'd0;
            r_wrdata  <= 8'd0;
            r_we      <= 1'b0;
        end else begin
            r_we <= 1'b0;

            if (r_state == S_IDLE) begin
                if (in_valid) begin
                    if (w_isPrint) begin
                        r_wraddr <= r_cursor;
                        r_wrdata <= in_data;
                        r_we     <= 1'b1;
                    end

                    if (w_lineAdvance) begin
                        r_col     <= 12'd0;
                        r_row     <= w_nextRow;
                        r_rowBase <= w_nextRowBase;
                        r_cursor  <= w_nextRowBase;
`ifdef CONSOLE_LINECLR_EN
                        r_state   <= S_LINECLR;
                        r_fill    <= w_nextRowBase;
                        r_fillEnd <= w_nextRowBase + LAST_COL;
`endif
                    end else if (w_isPrint) begin
                        r_col    <= r_col + 12'd1;
                        r_cursor <= r_cursor + 12'd1;
                    end else if (w_isCR) begin
                        r_col    <= 12'd0;
                        r_cursor <= r_rowBase;
                    end else if (w_isBS) begin
                        if (r_cursor != 12'd0) begin
                            r_col     <= w_prevCol;
                            r_row     <= w_prevRow;
                            r_rowBase <= w_prevRowBase;
                            r_cursor  <= r_cursor - 12'd1;
                        end
                    end else if (w_isFF) begin
                        r_col     <= 12'd0;
                        r_row     <= 12'd0;
                        r_rowBase <= 12'd0;
                        r_cursor  <= 12'd0;
                        r_state   <= S_CLEAR;
                        r_fill    <= 12'd0;
                        r_fillEnd <= LAST_ADDR;
                    end
                end
            end else begin
                r_wraddr <= r_fill;
                r_wrdata <= BLANK;
                r_we     <= 1'b1;
                if (r_fill == r_fillEnd) begin
                    r_state <= S_IDLE;
                end else begin
                    r_fill <= r_fill + 12'd1;
                end
            end
        end
    end

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign wraddr   = r_wraddr;
    assign wrdata   = r_wrdata;
    assign we       = r_we;
    assign cursor   = r_cursor;

endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer
//
// Testbench for text_console_writer.
//
// A reference model works with plain row/column arithmetic on a linear
// cursor. It keeps a queue of the display writes it expects. Every write the
// DUT performs is captured into a second queue. The two queues are compared
// after each directed step.
//
// When CONSOLE_LINECLR_EN is defined, the model also expects the row-blanking
// fills that follow each line advance.

module tb_text_console_writer;

    localparam int         COLS  = 80;
    localparam int         ROWS  = 30;
    localparam logic [7:0] BLANK = 8'h20;
    localparam int         BOUND = 6000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] wraddr;
    logic [7:0]  wrdata;
    logic        we;
    logic [11:0] cursor;
    logic        busy;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int mCursor = 0;
    logic [19:0] expQ[$];
    logic [19:0] obsQ[$];
    int          obsCyc[$];
    int          cycleCount = 0;

    text_console_writer #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .BLANK (BLANK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wraddr   (wraddr),
        .wrdata   (wrdata),
        .we       (we),
        .cursor   (cursor),
        .busy     (busy)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Record every display write shortly after the edge that produced it
    always @(posedge clk) begin
        #1;
        cycleCount++;
        if (we === 1'b1) begin
            obsQ.push_back({wraddr, wrdata});
            obsCyc.push_back(cycleCount);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Model: a full-screen blank fill
    task automatic modelClear();
        for (int a = 0; a < COLS * ROWS; a++) expQ.push_back({12'(a), BLANK});
    endtask

    // Model: move to column 0 of the next row (wrapping bottom to top)
    task automatic modelLineAdvance();
        int row;
        row = (mCursor / COLS + 1) % ROWS;
        mCursor = row * COLS;
`ifdef CONSOLE_LINECLR_EN
        for (int c = 0; c < COLS; c++) expQ.push_back({12'(row * COLS + c), BLANK});
`endif
    endtask

    // Model: effect of one accepted byte on the cursor and the expected write stream
    task automatic modelByte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            expQ.push_back({12'(mCursor), b});
            if (mCursor % COLS == COLS - 1) modelLineAdvance();
            else mCursor = mCursor + 1;
        end else if (b == 8'h0D) begin
            mCursor = (mCursor / COLS) * COLS;
        end else if (b == 8'h0A) begin
            modelLineAdvance();
        end else if (b == 8'h08) begin
            if (mCursor > 0) mCursor = mCursor - 1;
        end else if (b == 8'h0C) begin
            mCursor = 0;
            modelClear();
        end
    endtask

    // Present a byte, hold it until accepted, and return at the falling edge after acceptance
    task automatic applyStimulus(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) checkOutput("ready_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        modelByte(b);
    endtask

    // Wait (bounded) until the block is idle again
    task automatic waitIdle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(in_ready === 1'b1 && busy === 1'b0) && n < BOUND);
        if (n >= BOUND) checkOutput("idle_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
    endtask

    // Compare the captured write stream against the model's, then start fresh
    task automatic compareWrites(input string tag);
        int mism;
        int lim;
        mism = 0;
        lim = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < lim; i++) begin
            if (obsQ[i] !== expQ[i]) mism++;
        end
        checkOutput({tag, "_wrcount"}, obsQ.size(), expQ.size());
        checkOutput({tag, "_wrdiffs"}, mism, 0);
        obsQ.delete();
        obsCyc.delete();
        expQ.delete();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_we"}, {31'd0, we}, 32'd0);
        checkOutput({tag, "_wraddr"}, {20'd0, wraddr}, 32'd0);
        checkOutput({tag, "_wrdata"}, {24'd0, wrdata}, 32'd0);
        checkOutput({tag, "_cursor"}, {20'd0, cursor}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    // Directed steps followed by a randomized phase
    initial begin
        logic [7:0] b;
        int r;
        int n;

        // Reset and power-up clear
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        mCursor = 0;
        modelClear();
        waitIdle();
        compareWrites("reset_clear");
        checkOutput("reset_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_cursor", {20'd0, cursor}, 32'd0);

        // Back-to-back printable bytes
        applyStimulus(8'h41);
        applyStimulus(8'h42);
        checkOutput("ab_cursor", {20'd0, cursor}, 32'd2);
        waitIdle();
        if (obsCyc.size() >= 2) checkOutput("ab_consecutive", obsCyc[1] - obsCyc[0], 32'd1);
        else checkOutput("ab_writes_seen", obsCyc.size(), 32'd2);
        compareWrites("ab");

        // CR then LF
        applyStimulus(8'h0D);
        checkOutput("cr_cursor", {20'd0, cursor}, 32'd0);
        applyStimulus(8'h0A);
        checkOutput("lf_cursor", {20'd0, cursor}, 32'd80);
`ifdef CONSOLE_LINECLR_EN
        checkOutput("lf_fill_ready", {31'd0, in_ready}, 32'd0);
`endif
        waitIdle();
        compareWrites("crlf");

        // Walk to the last cell and wrap with a printable byte
        for (int i = 0; i < 28; i++) applyStimulus(8'h0A);
        checkOutput("lastrow_cursor", {20'd0, cursor}, 32'd2320);
        for (int i = 0; i < 79; i++) applyStimulus(8'h30 + 8'(i % 10));
        checkOutput("lastcell_cursor", {20'd0, cursor}, 32'd2399);
        applyStimulus(8'h58);
        checkOutput("wrap_cursor", {20'd0, cursor}, 32'd0);
        waitIdle();
        compareWrites("wrap");

        // Backspace at home, print, backspace
        applyStimulus(8'h08);
        checkOutput("bs_home_cursor", {20'd0, cursor}, 32'd0);
        applyStimulus(8'h41);
        checkOutput("bs_print_cursor", {20'd0, cursor}, 32'd1);
        applyStimulus(8'h08);
        checkOutput("bs_back_cursor", {20'd0, cursor}, 32'd0);
        waitIdle();
        compareWrites("bs");

        // Randomized byte stream (no FF)
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60) b = 8'($urandom_range(32, 126));
            else if (r < 70) b = 8'h0A;
            else if (r < 78) b = 8'h0D;
            else if (r < 88) b = 8'h08;
            else begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h0C) b = 8'h0B;
            end
            applyStimulus(b);
            checkOutput("rand_cursor", {20'd0, cursor}, 32'(mCursor));
        end
        waitIdle();
        compareWrites("rand");

        // FF with the next byte held during the clear
        applyStimulus(8'h0C);
        checkOutput("ff_ready_low", {31'd0, in_ready}, 32'd0);
        checkOutput("ff_busy", {31'd0, busy}, 32'd1);
        checkOutput("ff_cursor", {20'd0, cursor}, 32'd0);
        applyStimulus(8'h5A);
        checkOutput("held_cursor", {20'd0, cursor}, 32'd1);
        waitIdle();
        compareWrites("ff_held");

        // Reset in the middle of a clear
        applyStimulus(8'h0C);
        n = 0;
        while (!(we === 1'b1 && wraddr === 12'd1000) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midclear_reached", {20'd0, wraddr}, 32'd1000);
        rst = 1'b1;
        #1;
        checkResetOutputs("midreset");
        obsQ.delete();
        obsCyc.delete();
        expQ.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mCursor = 0;
        modelClear();
        waitIdle();
        compareWrites("restart_clear");
        checkOutput("restart_cursor", {20'd0, cursor}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
